// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding,
// active-low {g,f,e,d,c,b,a} segment patterns, and the preset digit clamp.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Presets come from raw switches; anything above 9 is clamped to 9.
  function automatic logic [3:0] sat_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decode {g,f,e,d,c,b,a}.
module bcd_to_7seg
  import bcd_countdown_timer_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer (99..00) with prescaled tick, done pulse
// and a multiplexed 2-digit 7-segment driver, all on clk with enables.
//   state  | meaning
//   IDLE   | preset loaded, not counting
//   RUN    | counting down once per tick
//   PAUSED | count and prescaler frozen
//   DONE   | reached 00, waits for load or clr
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] in_tens,
  input  logic [3:0] in_ones,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  state_t          state;
  logic [PW-1:0]   pre;
  logic            tick_en;
  logic [3:0]      dec_tens, dec_ones;
  logic            dec_zero;
  logic [SW-1:0]   scan_cnt;
  logic            sel;
  logic            sel_next;
  logic [3:0]      scan_digit;
  logic [6:0]      seg_next;

  assign tick_en = (state == RUN) && (pre == PRE_MAX);

  always_comb begin
    dec_tens = tens;
    dec_ones = ones;
    if (ones != 4'd0) begin
      dec_ones = ones - 4'd1;
    end else begin
      dec_ones = 4'd9;
      dec_tens = tens - 4'd1;
    end
  end

  assign dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      tens    <= 4'd0;
      ones    <= 4'd0;
      pre     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        tens    <= sat_bcd(in_tens);
        ones    <= sat_bcd(in_ones);
        pre     <= '0;
        state   <= IDLE;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            pre <= '0;
            if (start && !pause) begin
              if (tens == 4'd0 && ones == 4'd0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state   <= RUN;
                running <= 1'b1;
              end
            end
          end
          RUN: begin
            // Reaching 00 wins over a pause arriving on the same tick.
            if (tick_en) begin
              pre  <= '0;
              tens <= dec_tens;
              ones <= dec_ones;
              if (dec_zero) begin
                state   <= DONE;
                done    <= 1'b1;
                running <= 1'b0;
              end else if (pause) begin
                state   <= PAUSED;
                running <= 1'b0;
              end
            end else begin
              pre <= pre + PW'(1);
              if (pause) begin
                state   <= PAUSED;
                running <= 1'b0;
              end
            end
          end
          PAUSED: begin
            if (start && !pause) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            pre <= '0;
          end
        endcase
      end
    end
  end

  assign sel_next   = (scan_cnt == SCAN_MAX) ? ~sel : sel;
  assign scan_digit = sel_next ? tens : ones;

  bcd_to_7seg u_dec (
    .digit (scan_digit),
    .seg   (seg_next)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      scan_cnt <= '0;
      sel      <= 1'b0;
      an       <= 2'b10;
      seg      <= SEG_0;
    end else begin
      scan_cnt <= (scan_cnt == SCAN_MAX) ? '0 : scan_cnt + SW'(1);
      sel      <= sel_next;
      an       <= sel_next ? 2'b01 : 2'b10;
      seg      <= seg_next;
    end
  end

endmodule
